uart_cmd_parser: RTL and testbench

//  Command layer between the UART receiver FIFO and the UART transmitter. Pops bytes from the

---
 rtl/uart_cmd_parser.sv | 139 +++++++++++++
 tb/tb_uart_cmd_parser.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_parser.sv
// Command layer between the UART receive FIFO and the transmitter. It frames 5-byte
// register commands (SYNC, CMD, ADDR, DATA, CHK), drives a register bus and returns ACK/NAK.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 2_500_000,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] r_data,
  output logic       rd_uart,
  input  logic       tx_full,
  output logic [7:0] w_data,
  output logic       wr_uart,
  output logic [7:0] reg_addr,
  output logic [7:0] reg_wdata,
  output logic       reg_we,
  output logic       reg_re,
  input  logic [7:0] reg_rdata,
  output logic [7:0] err_cnt
);

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam int         TW        = $clog2(TIMEOUT_CYCLES);

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_GET_CMD   = 4'd1;
  localparam logic [3:0] ST_GET_ADDR  = 4'd2;
  localparam logic [3:0] ST_GET_DATA  = 4'd3;
  localparam logic [3:0] ST_GET_CHK   = 4'd4;
  localparam logic [3:0] ST_EXEC      = 4'd5;
  localparam logic [3:0] ST_RD_WAIT   = 4'd6;
  localparam logic [3:0] ST_SEND_ACK  = 4'd7;
  localparam logic [3:0] ST_SEND_DATA = 4'd8;
  localparam logic [3:0] ST_SEND_NAK  = 4'd9;

  logic [3:0]    state;
  logic [7:0]    cmd_q, addr_q, data_q, chk_q, rdata_q;
  logic          pop_last;
  logic [TW-1:0] tmo_cnt;

  logic in_get, in_send, timeout, frame_ok, err_inc;

  assign in_get   = (state >= ST_GET_CMD) && (state <= ST_GET_CHK);
  assign in_send  = (state == ST_SEND_ACK) || (state == ST_SEND_DATA) || (state == ST_SEND_NAK);
  assign frame_ok = (chk_q == (cmd_q ^ addr_q ^ data_q)) &&
                    ((cmd_q == CMD_WRITE) || (cmd_q == CMD_READ));

  // The gap after every pop lets the FIFO advance its head before the next read.
  assign rd_uart = rst && !rx_empty && !pop_last && (in_get || (state == ST_IDLE));
  assign wr_uart = rst && in_send && !tx_full;
  assign reg_we  = rst && (state == ST_EXEC) && frame_ok && (cmd_q == CMD_WRITE);
  assign reg_re  = rst && (state == ST_EXEC) && frame_ok && (cmd_q == CMD_READ);

  // A pop in the same cycle as the timeout wins.
  assign timeout = in_get && !rd_uart && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  assign err_inc = timeout || ((state == ST_EXEC) && !frame_ok);

  assign reg_addr  = addr_q;
  assign reg_wdata = data_q;

  // NOTE: always_comb assigns a default before the case so no path leaves w_data unassigned
  // and no latch is inferred.
  always_comb begin
    w_data = 8'h00;
    case (state)
      ST_SEND_ACK:  w_data = ACK_BYTE;
      ST_SEND_DATA: w_data = rdata_q;
      ST_SEND_NAK:  w_data = NAK_BYTE;
      default:      w_data = 8'h00;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every register samples the
  // pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= ST_IDLE;
      cmd_q    <= 8'h00;
      addr_q   <= 8'h00;
      data_q   <= 8'h00;
      chk_q    <= 8'h00;
      rdata_q  <= 8'h00;
      pop_last <= 1'b0;
      tmo_cnt  <= '0;
      err_cnt  <= 8'h00;
    end else begin
      pop_last <= rd_uart;

      if (!in_get || rd_uart || timeout) tmo_cnt <= '0;
      else                               tmo_cnt <= tmo_cnt + TW'(1);

      if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;

      case (state)
        ST_IDLE:
          if (rd_uart && (r_data == SYNC_BYTE)) state <= ST_GET_CMD;
        ST_GET_CMD:
          if (rd_uart) begin
            cmd_q <= r_data;
            state <= ST_GET_ADDR;
          end else if (timeout) state <= ST_IDLE;
        ST_GET_ADDR:
          if (rd_uart) begin
            addr_q <= r_data;
            state  <= ST_GET_DATA;
          end else if (timeout) state <= ST_IDLE;
        ST_GET_DATA:
          if (rd_uart) begin
            data_q <= r_data;
            state  <= ST_GET_CHK;
          end else if (timeout) state <= ST_IDLE;
        ST_GET_CHK:
          if (rd_uart) begin
            chk_q <= r_data;
            state <= ST_EXEC;
          end else if (timeout) state <= ST_IDLE;
        ST_EXEC:
          if (!frame_ok)               state <= ST_SEND_NAK;
          else if (cmd_q == CMD_WRITE) state <= ST_SEND_ACK;
          else                         state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          rdata_q <= reg_rdata;
          state   <= ST_SEND_ACK;
        end
        ST_SEND_ACK:
          if (wr_uart) state <= (cmd_q == CMD_READ) ? ST_SEND_DATA : ST_IDLE;
        ST_SEND_DATA, ST_SEND_NAK:
          if (wr_uart) state <= ST_IDLE;
        default:
          state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: a FIFO model feeds bytes, a frame-level
// reference model predicts TX bytes, register strobes and the error count.
module tb_uart_cmd_parser;

  localparam logic [7:0] SYNC = 8'hA5;
  localparam logic [7:0] ACK  = 8'h06;
  localparam logic [7:0] NAK  = 8'h15;

  logic       clk, rst;
  logic       rx_empty, rd_uart, tx_full, wr_uart, reg_we, reg_re;
  logic [7:0] r_data, w_data, reg_addr, reg_wdata, reg_rdata, err_cnt;

  uart_cmd_parser #(.TIMEOUT_CYCLES(1000)) dut (
    .clk(clk), .rst(rst), .rx_empty(rx_empty), .r_data(r_data), .rd_uart(rd_uart),
    .tx_full(tx_full), .w_data(w_data), .wr_uart(wr_uart), .reg_addr(reg_addr),
    .reg_wdata(reg_wdata), .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
    .err_cnt(err_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got 0x%0h expected no such event at %0t", name, act, $time);
  endtask

  // ---------------- reference model ----------------
  logic [7:0]  fifo_q[$];
  logic [7:0]  frame_buf[$];
  logic [7:0]  tx_q[$];
  logic [15:0] we_q[$];
  logic [7:0]  re_q[$];
  int          model_err = 0;

  task automatic model_feed(input logic [7:0] b);
    logic [7:0] c, a, d, k;
    if (frame_buf.size() == 0 && b != SYNC) return;
    frame_buf.push_back(b);
    if (frame_buf.size() < 5) return;
    c = frame_buf[1]; a = frame_buf[2]; d = frame_buf[3]; k = frame_buf[4];
    frame_buf.delete();
    if (k != (c ^ a ^ d) || (c != 8'h57 && c != 8'h52)) begin
      tx_q.push_back(NAK);
      if (model_err < 255) model_err++;
    end else if (c == 8'h57) begin
      we_q.push_back({a, d});
      tx_q.push_back(ACK);
    end else begin
      re_q.push_back(a);
      tx_q.push_back(ACK);
      tx_q.push_back(reg_rdata);
    end
  endtask

  task automatic model_timeout();
    frame_buf.delete();
    if (model_err < 255) model_err++;
  endtask

  task automatic push_bytes(input logic [7:0] b[]);
    foreach (b[i]) begin
      fifo_q.push_back(b[i]);
      model_feed(b[i]);
    end
  endtask

  // ---------------- receiver FIFO model ----------------
  int pops = 0;
  initial begin
    logic pop_pending;
    rx_empty = 1'b1;
    r_data   = 8'h00;
    forever begin
      @(negedge clk);
      pop_pending = rd_uart;
      @(posedge clk);
      #1;
      if (pop_pending && fifo_q.size() > 0) begin
        void'(fifo_q.pop_front());
        pops++;
      end
      rx_empty = (fifo_q.size() == 0);
      r_data   = rx_empty ? 8'h00 : fifo_q[0];
    end
  end

  // ---------------- per-cycle compare ----------------
  int         cyc = 0;
  int         tx_count, we_count, re_count, we_cycle, re_cycle;
  int         tx_log[$];
  logic [7:0] last_tx;

  initial begin
    logic prev_rd;
    prev_rd = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        if (rd_uart) begin
          check("rd_uart_gap", {31'd0, prev_rd}, 32'd0);
          check("rd_uart_when_empty", {31'd0, rx_empty}, 32'd0);
        end
        if (wr_uart) begin
          check("wr_uart_while_full", {31'd0, tx_full}, 32'd0);
          if (tx_q.size() == 0) note_fail("tx_extra_byte", {24'd0, w_data});
          else check("w_data", {24'd0, w_data}, {24'd0, tx_q.pop_front()});
          tx_count++;
          last_tx = w_data;
          tx_log.push_back(cyc);
        end
        if (reg_we) begin
          if (we_q.size() == 0) note_fail("reg_we_extra", {16'd0, reg_addr, reg_wdata});
          else check("reg_we_addr_data", {16'd0, reg_addr, reg_wdata}, {16'd0, we_q.pop_front()});
          we_count++;
          we_cycle = cyc;
        end
        if (reg_re) begin
          if (re_q.size() == 0) note_fail("reg_re_extra", {24'd0, reg_addr});
          else check("reg_re_addr", {24'd0, reg_addr}, {24'd0, re_q.pop_front()});
          re_count++;
          re_cycle = cyc;
        end
      end
      prev_rd = rd_uart;
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_stats();
    tx_count = 0; we_count = 0; re_count = 0;
    we_cycle = 0; re_cycle = 0;
    tx_log.delete();
    last_tx = 8'h00;
  endtask

  task automatic wait_quiet(input string name);
    int n = 0;
    while ((fifo_q.size() != 0 || tx_q.size() != 0 || we_q.size() != 0 || re_q.size() != 0)
           && n < 500) begin
      tick();
      n++;
    end
    if (n >= 500) note_fail({name, "_quiet_timeout"}, n);
    tick(4);
    check({name, "_err_cnt_model"}, {24'd0, err_cnt}, model_err);
  endtask

  task automatic wait_pops(input string name, input int target);
    int n = 0;
    while (pops < target && n < 200) begin
      tick();
      n++;
    end
    if (n >= 200) note_fail({name, "_pop_timeout"}, pops);
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_rd_uart"},   {31'd0, rd_uart}, 32'd0);
    check({name, "_wr_uart"},   {31'd0, wr_uart}, 32'd0);
    check({name, "_reg_we"},    {31'd0, reg_we},  32'd0);
    check({name, "_reg_re"},    {31'd0, reg_re},  32'd0);
    check({name, "_w_data"},    {24'd0, w_data},  32'd0);
    check({name, "_reg_addr"},  {24'd0, reg_addr}, 32'd0);
    check({name, "_reg_wdata"}, {24'd0, reg_wdata}, 32'd0);
    check({name, "_err_cnt"},   {24'd0, err_cnt}, 32'd0);
  endtask

  // ---------------- directed tests ----------------
  initial begin
    int base;
    rst       = 1'b0;
    tx_full   = 1'b0;
    reg_rdata = 8'h00;
    clear_stats();
    tick(3);
    check_idle_outputs("reset");
    rst = 1'b1;
    tick(2);

    // 1: write frame
    clear_stats();
    push_bytes('{8'hA5, 8'h57, 8'h10, 8'h3C, 8'h7B});
    wait_quiet("write");
    check("write_err_cnt", {24'd0, err_cnt}, 32'd0);
    check("write_tx_count", tx_count, 1);
    check("write_tx_byte", {24'd0, last_tx}, 32'h06);
    check("write_we_count", we_count, 1);
    if (tx_log.size() > 0) check("write_ack_latency", tx_log[0] - we_cycle, 1);

    // 2: read frame
    clear_stats();
    reg_rdata = 8'h5A;
    push_bytes('{8'hA5, 8'h52, 8'h22, 8'h00, 8'h70});
    wait_quiet("read");
    check("read_tx_count", tx_count, 2);
    check("read_we_count", we_count, 0);
    check("read_re_count", re_count, 1);
    check("read_data_byte", {24'd0, last_tx}, 32'h5A);
    if (tx_log.size() == 2) begin
      check("read_ack_latency", tx_log[0] - re_cycle, 2);
      check("read_data_latency", tx_log[1] - tx_log[0], 1);
    end

    // 3: bad checksum, then bad command
    clear_stats();
    push_bytes('{8'hA5, 8'h57, 8'h10, 8'h3C, 8'h00});
    wait_quiet("bad_chk");
    check("bad_chk_err_cnt", {24'd0, err_cnt}, 32'd1);
    check("bad_chk_tx_byte", {24'd0, last_tx}, 32'h15);
    check("bad_chk_no_strobe", we_count + re_count, 0);
    clear_stats();
    push_bytes('{8'hA5, 8'h41, 8'h10, 8'h3C, 8'h6D});
    wait_quiet("bad_cmd");
    check("bad_cmd_err_cnt", {24'd0, err_cnt}, 32'd2);
    check("bad_cmd_tx_byte", {24'd0, last_tx}, 32'h15);

    // 4: garbage before a frame
    clear_stats();
    base = pops;
    push_bytes('{8'h00, 8'hFF, 8'h33, 8'hA5, 8'h57, 8'h10, 8'h3C, 8'h7B});
    wait_quiet("garbage");
    check("garbage_pops", pops - base, 8);
    check("garbage_tx_count", tx_count, 1);
    check("garbage_tx_byte", {24'd0, last_tx}, 32'h06);
    check("garbage_err_cnt", {24'd0, err_cnt}, 32'd2);

    // 5: inter-byte timeout
    clear_stats();
    base = pops;
    push_bytes('{8'hA5, 8'h57});
    wait_pops("timeout", base + 2);
    tick(990);
    check("timeout_not_early", {24'd0, err_cnt}, 32'd2);
    tick(20);
    model_timeout();
    check("timeout_err_cnt", {24'd0, err_cnt}, 32'd3);
    check("timeout_no_tx", tx_count, 0);
    push_bytes('{8'hA5, 8'h57, 8'h10, 8'h3C, 8'h7B});
    wait_quiet("after_timeout");
    check("after_timeout_tx_byte", {24'd0, last_tx}, 32'h06);
    check("after_timeout_err_cnt", {24'd0, err_cnt}, 32'd3);

    // 6a: transmitter back-pressure
    clear_stats();
    tx_full = 1'b1;
    push_bytes('{8'hA5, 8'h57, 8'h10, 8'h3C, 8'h7B});
    begin
      int n = 0;
      while (we_count == 0 && n < 100) begin
        tick();
        n++;
      end
      if (n >= 100) note_fail("txfull_we_timeout", we_count);
    end
    tick(100);
    check("txfull_stalled", tx_count, 0);
    tx_full = 1'b0;
    tick();
    check("txfull_released", tx_count, 1);
    wait_quiet("txfull");
    check("txfull_tx_byte", {24'd0, last_tx}, 32'h06);

    // 6b: reset in the middle of a frame
    clear_stats();
    base = pops;
    push_bytes('{8'hA5, 8'h57, 8'h10});
    wait_pops("midreset", base + 3);
    tick();
    rst = 1'b0;
    frame_buf.delete();
    model_err = 0;
    tick(2);
    check_idle_outputs("midreset");
    rst = 1'b1;
    tick(2);
    push_bytes('{8'hA5, 8'h57, 8'h10, 8'h3C, 8'h7B});
    wait_quiet("after_reset");
    check("after_reset_tx_count", tx_count, 1);
    check("after_reset_tx_byte", {24'd0, last_tx}, 32'h06);
    check("after_reset_err_cnt", {24'd0, err_cnt}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
